// File: rtl/riscv_mc_main_fsm.sv
// Main control FSM for the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the 2-bit ALUOp, with a memory-ready stall handshake.
module riscv_mc_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic               illegal_instr,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECUTEI = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
        w_next       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC+imm is precomputed here so BEQ only needs the compare.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECUTER;
          OP_I:         w_next = EXECUTEI;
          OP_JAL:       w_next = JAL;
          OP_BEQ:       w_next = BEQ;
          default: begin
            w_illegal = 1'b1;
            w_next    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = mem_ready;
        w_next      = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = ALUWB;
      end
      EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = ALUWB;
      end
      JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = ALUWB;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // Every output is gated by rst_n so nothing (including FETCH's Moore values) leaks during reset.
  assign pc_write      = rst_n & (w_pc_update | (w_branch & zero));
  assign adr_src       = rst_n & w_adr_src;
  assign mem_write     = rst_n & w_mem_write;
  assign ir_write      = rst_n & w_ir_write;
  assign result_src    = {2{rst_n}} & w_result_src;
  assign alu_src_a     = {2{rst_n}} & w_alu_src_a;
  assign alu_src_b     = {2{rst_n}} & w_alu_src_b;
  assign alu_op        = {2{rst_n}} & w_alu_op;
  assign imm_src       = {2{rst_n}} & w_imm_src;
  assign reg_write     = rst_n & w_reg_write;
  assign illegal_instr = rst_n & w_illegal;
  assign instr_done    = rst_n & w_done;
  assign state_o       = rst_n ? r_state : '0;

endmodule

// File: tb/tb_riscv_mc_main_fsm.sv
// Self-checking bench for riscv_mc_main_fsm: directed test-plan steps followed by randomized
// instructions, all checked against an instruction-level reference model of the control sequence.
module tb_riscv_mc_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr, instr_done;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0]  state_o;
  logic [16:0] obsVec;

  int total = 0;
  int bad = 0;
  int expState = 0;
  int pathQ[$];
  int mwCount = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  riscv_mc_main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .instr_done(instr_done), .state_o(state_o)
  );

  assign obsVec = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                   alu_op, imm_src, reg_write, illegal_instr, instr_done};

  // Expected control word for a given step of an instruction, packed like obsVec.
  function automatic logic [16:0] expOut(int s, logic [6:0] o, logic mr, logic z);
    logic pcw, adr, mw, irw, rw, ill, done;
    logic [1:0] res, a, b, aop, imm;
    bit legal;
    {pcw, adr, mw, irw, rw, ill, done} = '0;
    {res, a, b, aop} = '0;
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    legal = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
    case (s)
      0:  begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      1:  begin a = 2'b01; b = 2'b01; ill = !legal; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; done = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; done = mr; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  begin rw = 1'b1; done = 1'b1; end
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      10: begin a = 2'b10; aop = 2'b01; pcw = z; done = 1'b1; end
      default: imm = 2'b00;
    endcase
    return {pcw, adr, mw, irw, res, a, b, aop, imm, rw, ill, done};
  endfunction

  // The remaining steps of an instruction are planned when it is decoded, then consumed one per cycle.
  task automatic advanceModel(logic [6:0] o, logic mr);
    if ((expState == 0 || expState == 3 || expState == 5) && !mr) return;
    if (expState == 0) begin
      expState = 1;
    end else begin
      if (expState == 1) begin
        pathQ.delete();
        case (o)
          LW: begin pathQ.push_back(2); pathQ.push_back(3); pathQ.push_back(4); end
          SW: begin pathQ.push_back(2); pathQ.push_back(5); end
          RT: begin pathQ.push_back(6); pathQ.push_back(7); end
          IT: begin pathQ.push_back(8); pathQ.push_back(7); end
          JL: begin pathQ.push_back(9); pathQ.push_back(7); end
          BQ: pathQ.push_back(10);
          default: ;
        endcase
      end
      expState = (pathQ.size() == 0) ? 0 : pathQ.pop_front();
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, then step the model.
  task automatic applyStimulus(logic [6:0] o, logic mr, logic z);
    op = o;
    mem_ready = mr;
    zero = z;
    #3;
    checkOutput($sformatf("state@%0d", expState), 32'(state_o), 32'(expState));
    checkOutput($sformatf("ctrl@%0d_op%0h", expState, o), 32'(obsVec), 32'(expOut(expState, o, mr, z)));
    if (mem_write) mwCount++;
    if (instr_done) doneCount++;
    advanceModel(o, mr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] curOp;
    logic [6:0] opTable [8];
    opTable = '{LW, SW, RT, IT, JL, BQ, 7'b0000000, 7'b1111111};

    rst_n = 1'b0;
    op = 7'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    #2;
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_outputs", 32'(obsVec), 32'd0);
    mem_ready = 1'b1;
    op = JL;
    zero = 1'b1;
    #1;
    checkOutput("reset_masks_fetch", 32'(obsVec), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    doneCount = 0;
    repeat (5) applyStimulus(LW, 1'b1, 1'b0);
    checkOutput("lw_done_pulses", 32'(doneCount), 32'd1);
    checkOutput("lw_back_in_fetch", 32'(state_o), 32'd0);

    mwCount = 0;
    repeat (3) applyStimulus(SW, 1'b1, 1'b0);
    repeat (3) applyStimulus(SW, 1'b0, 1'b0);
    applyStimulus(SW, 1'b1, 1'b0);
    checkOutput("sw_memwrite_cycles", 32'(mwCount), 32'd4);

    repeat (2) applyStimulus(RT, 1'b0, 1'b0);
    repeat (4) applyStimulus(RT, 1'b1, 1'b0);
    repeat (4) applyStimulus(IT, 1'b1, 1'b1);

    repeat (3) applyStimulus(BQ, 1'b1, 1'b1);
    repeat (3) applyStimulus(BQ, 1'b1, 1'b0);
    checkOutput("beq_back_in_fetch", 32'(state_o), 32'd0);

    repeat (4) applyStimulus(JL, 1'b1, 1'b0);
    repeat (2) applyStimulus(7'b0000000, 1'b1, 1'b0);
    checkOutput("illegal_back_in_fetch", 32'(state_o), 32'd0);

    repeat (3) applyStimulus(LW, 1'b1, 1'b0);
    op = LW;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_state", 32'(state_o), 32'd0);
    checkOutput("async_reset_outputs", 32'(obsVec), 32'd0);
    expState = 0;
    pathQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    curOp = LW;
    for (int i = 0; i < 600; i++) begin
      if (expState == 0) curOp = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opTable[$urandom_range(0, 7)];
      applyStimulus(curOp, 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mc_main_fsm.md
Name: riscv_mc_main_fsm

Overview:
Main control state machine for the multi-cycle RISC-V core. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal. It generates every datapath enable and mux select, plus the 2-bit ALUOp that feeds the existing ALU decoder; ALUControl is not produced here. It supports a memory-ready handshake so that a shared instruction/data memory can stall the core.

Parameters:
STATE_W, 4, width of the state register and of the state_o debug port

Ports:
clk  in  1  core clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0] from the instruction register
zero  in  1  ALU zero flag, valid in the BEQ state
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC register enable = pc_update | (branch & zero)
adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register and OldPC enable
result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = RD1
alu_src_b  out  2  SrcB mux: 00 = RD2, 01 = ImmExt, 10 = constant 4
alu_op  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
imm_src  out  2  immediate format select
reg_write  out  1  register file write enable
illegal_instr  out  1  one-cycle pulse in DECODE when the opcode is unsupported
instr_done  out  1  one-cycle pulse in the last state of each instruction
state_o  out  STATE_W  current state, debug only

Behaviour:
- Reset: rst_n=0 forces state FETCH asynchronously. While reset is asserted, all outputs are 0 and state_o is 0; the FETCH Moore outputs are masked. Reset mid-instruction abandons that instruction, and no write strobe is asserted during reset.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11 to 15 are unreachable; if entered, the next state is FETCH and all outputs are 0.
- Outputs are Moore outputs, except pc_write (uses zero) and the mem_ready gating. Any output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precomputed). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH, with illegal_instr=1 for that cycle
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready=1. Then instr_done=1 and next is FETCH. mem_write stays high for every stall cycle.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next is FETCH. pc_write=zero in this state.
- imm_src is combinational from op in every state: 0000011 and 0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle.

Test Plan:
1. Reset, then mem_ready=1 and op=0000011 (lw) -> state_o sequence 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. instr_done pulses once.
2. op=0100011 (sw) with mem_ready=0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH. reg_write stays 0 and imm_src=01 throughout.
3. op=0110011, then op=0010011 -> states 0,1,6,7 then 0,1,8,7. alu_op=10 in states 6 and 8. alu_src_b=00 in state 6 and 01 in state 8.
4. op=1100011 (beq) with zero=1, then with zero=0 -> in BEQ, pc_write is 1 then 0, alu_op=01, imm_src=10. Instruction takes 3 cycles.
5. op=1101111 (jal) -> states 0,1,9,7. pc_write=1 in both FETCH and JAL. alu_src_a=01 and alu_src_b=10 in JAL. imm_src=11.
6. op=0000000 in DECODE -> illegal_instr pulses for 1 cycle, then FETCH. Separately, assert rst_n=0 in MEMREAD -> state_o=0 and all outputs 0 immediately, without waiting for a clock edge.
